gtxe2_chnl_tx_ser_mw: RTL and testbench
=======================================

# gtxe2_chnl_tx_ser_mw

Single-clock, multi-width TX serializer for the GTXE2 channel model. It accepts parallel words through a valid/ready handshake into a small word FIFO and shifts them out one bit per `outclk`. The serial width is selectable at run time among 16/20/32/40 bits, latched per word. When the FIFO runs dry it inserts an electrical-idle word instead of stalling. It sits between the TX gearbox/8b10b output and the TX PMA driver model.

## Interface
Parameters:
- `max_width`, 40, width of `in_data`; must be ≥ 40.
- `log_depth`, 2, word FIFO depth is 2^log_depth words (each word max_width+1 bits incl. idle flag).

Ports (one clock; reset is synchronous and active-high):
- `outclk`  in  1  serial bit clock; all logic on posedge.
- `reset`  in  1  synchronous, active-high; flushes FIFO, returns to IDLE.
- `width_sel`  in  2  0:16, 1:20, 2:32, 3:40 bits; sampled only at word load.
- `in_data`  in  max_width  parallel word; bits above active width ignored.
- `in_idle`  in  1  word is electrical idle (TXP=TXN=0).
- `in_val`  in  1  word valid.
- `in_rdy`  out  1  FIFO not full; transfer when `in_val & in_rdy`.
- `outdata`  out  1  serial bit.
- `idle_out`  out  1  current bit belongs to an idle word or an underflow-fill period.
- `word_start`  out  1  high with the first bit of each word on `outdata`.
- `underflow`  out  1  one-cycle pulse when a word boundary finds the FIFO empty.

## Operation
- FIFO: 2^log_depth entries of {in_idle, in_data}; count register 0..2^log_depth. `in_rdy = (count != 2^log_depth)`, from registers only. Push and pop in the same cycle allowed; count unchanged. `in_val` while `in_rdy`=0 is ignored (no overwrite).
- States: IDLE (nothing loaded), RUN (word loaded, bitcounter shifting).
- Load cycle: IDLE every cycle, or RUN when bitcounter == W-1 (W = latched width). If FIFO non-empty: pop, latch word, flag and `width_sel` → W, bitcounter ← 0, state RUN. If empty in RUN: state IDLE, `underflow` pulse. If empty in IDLE: stay.
- RUN: bitcounter increments 0..W-1. Bit emitted is word[bitcounter] (LSB first).
- Registered outputs, updated each cycle from current state: RUN → `outdata` = selected bit, `idle_out` = latched flag (an idle word drives `outdata`=0), `word_start` = (bitcounter==0). IDLE → `outdata`=0, `idle_out`=1, `word_start`=0.
- IDLE restart is not word-aligned: the first word after underflow starts on the cycle after it becomes available.
- `width_sel` changes mid-word have no effect until the next load.

## Timing
- Reset values, cycle after `reset` high: `outdata`=0, `idle_out`=1, `word_start`=0, `underflow`=0, `in_rdy`=1, count=0, bitcounter=0, state IDLE.
- Reset mid-word aborts the word. FIFO contents are discarded. A push coincident with reset is dropped.
- Latency from an empty IDLE state: word accepted at cycle t, popped at t+1, first bit on `outdata` with `word_start` at t+2.
- Back-to-back words with a non-empty FIFO: no gap. Bit W-1 of word n is followed directly by bit 0 of word n+1.
- `underflow` is asserted in the cycle after the boundary, aligned with the first fill bit (`idle_out`=1).

## Configuration
- `GTXE2_TX_SER_MSB_FIRST_EN`
  - Defined: emitted bit is word[W-1-bitcounter], i.e. MSB of the active width first.
  - Undefined: LSB first, word[bitcounter].
  - All timing and handshakes are identical in both builds.

## Test plan
- Reset, then width_sel=1, push 20'hA5F0F → from t+2, 20 bits LSB-first 1,1,1,1,0,0,0,0,1,1,1,1,1,0,1,0,0,1,0,1. `word_start` on bit 0. Then `underflow` pulse, `idle_out`=1.
- Stream 8 words at width 16 with `in_val` held high → continuous 128 bits with no gap. `word_start` every 16 cycles. `in_rdy` drops when count=4, and `underflow` never fires until the stream ends.
- Push 32-bit word, then a 40-bit word with width_sel toggled mid-word → first word 32 bits, second 40 bits. The toggle has no effect on the word already in progress.
- Push a word with `in_idle`=1, data 16'hFFFF → 16 cycles of `outdata`=0, `idle_out`=1, `word_start` on the first.
- Assert reset at bit 7 of a word with 3 words queued → outputs take reset values next cycle. `in_rdy`=1, and no queued word is ever emitted.
- Build with `GTXE2_TX_SER_MSB_FIRST_EN`, width 16, word 16'h8001 → `outdata` 1, 0×14, 1.

Source files
------------

// File: rtl/gtxe2_chnl_tx_ser_mw.sv
// Multi-width (16/20/32/40) TX serializer with a word FIFO and idle fill on underflow.
// Optional build macro GTXE2_TX_SER_MSB_FIRST_EN selects MSB-first bit order.
module gtxe2_chnl_tx_ser_mw #(
  parameter int max_width = 40,
  parameter int log_depth = 2
) (
  input  logic                 outclk,
  input  logic                 reset,
  input  logic [1:0]           width_sel,
  input  logic [max_width-1:0] in_data,
  input  logic                 in_idle,
  input  logic                 in_val,
  output logic                 in_rdy,
  output logic                 outdata,
  output logic                 idle_out,
  output logic                 word_start,
  output logic                 underflow
);

  localparam int unsigned      depth    = 1 << log_depth;
  localparam logic [log_depth:0]   full_cnt = (log_depth + 1)'(depth);
  localparam logic [log_depth:0]   cnt_one  = (log_depth + 1)'(1);
  localparam logic [log_depth-1:0] ptr_one  = log_depth'(1);

  typedef enum logic {ST_IDLE, ST_RUN} state_t;

  logic [max_width:0]   mem_q [depth];
  logic [log_depth-1:0] wr_ptr_q, rd_ptr_q;
  logic [log_depth:0]   count_q;

  state_t               state_q, state_d;
  logic [5:0]           bitcnt_q, bitcnt_d;
  logic [1:0]           wsel_q;
  logic [max_width-1:0] word_q;
  logic                 flag_q;
  logic                 uf_pend_q, uf_pend_d;

  logic                 outdata_q, idle_out_q, word_start_q, underflow_q;

  logic                 push, pop, last_bit, sel_bit;
  logic [5:0]           last_idx, bit_idx;
  logic [max_width-1:0] word_sh;

  always_comb begin
    case (wsel_q)
      2'd0:    last_idx = 6'd15;
      2'd1:    last_idx = 6'd19;
      2'd2:    last_idx = 6'd31;
      default: last_idx = 6'd39;
    endcase
  end

  assign in_rdy   = (count_q != full_cnt);
  assign push     = in_val & in_rdy;
  assign last_bit = (bitcnt_q == last_idx);

`ifdef GTXE2_TX_SER_MSB_FIRST_EN
  assign bit_idx = last_idx - bitcnt_q;
`else
  assign bit_idx = bitcnt_q;
`endif
  assign word_sh = word_q >> bit_idx;
  assign sel_bit = word_sh[0];

  // Load decision: a word boundary (IDLE, or the last bit in RUN) pops if anything is queued.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    state_d   = state_q;
    bitcnt_d  = bitcnt_q;
    pop       = 1'b0;
    uf_pend_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (count_q != '0) begin
          pop      = 1'b1;
          state_d  = ST_RUN;
          bitcnt_d = '0;
        end
      end
      ST_RUN: begin
        if (last_bit) begin
          bitcnt_d = '0;
          if (count_q != '0) begin
            pop = 1'b1;
          end else begin
            state_d   = ST_IDLE;
            uf_pend_d = 1'b1;
          end
        end else begin
          bitcnt_d = bitcnt_q + 6'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: the FIFO storage has no reset; count and pointers alone define what is valid.
  always_ff @(posedge outclk) begin
    if (push && !reset) begin
      mem_q[wr_ptr_q] <= {in_idle, in_data};
    end
  end

  always_ff @(posedge outclk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      state_q      <= ST_IDLE;
      bitcnt_q     <= '0;
      wsel_q       <= '0;
      word_q       <= '0;
      flag_q       <= 1'b0;
      uf_pend_q    <= 1'b0;
      outdata_q    <= 1'b0;
      idle_out_q   <= 1'b1;
      word_start_q <= 1'b0;
      underflow_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      bitcnt_q  <= bitcnt_d;
      uf_pend_q <= uf_pend_d;

      if (push) wr_ptr_q <= wr_ptr_q + ptr_one;
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + ptr_one;
        word_q   <= mem_q[rd_ptr_q][max_width-1:0];
        flag_q   <= mem_q[rd_ptr_q][max_width];
        wsel_q   <= width_sel;
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + cnt_one;
        2'b01:   count_q <= count_q - cnt_one;
        default: count_q <= count_q;
      endcase

      // Outputs reflect the pre-edge state; underflow is delayed to line up with the first fill bit.
      if (state_q == ST_RUN) begin
        outdata_q    <= sel_bit & ~flag_q;
        idle_out_q   <= flag_q;
        word_start_q <= (bitcnt_q == 6'd0);
      end else begin
        outdata_q    <= 1'b0;
        idle_out_q   <= 1'b1;
        word_start_q <= 1'b0;
      end
      underflow_q <= uf_pend_q;
    end
  end

  assign outdata    = outdata_q;
  assign idle_out   = idle_out_q;
  assign word_start = word_start_q;
  assign underflow  = underflow_q;

endmodule

// File: tb/tb_gtxe2_chnl_tx_ser_mw.sv
// Bench for gtxe2_chnl_tx_ser_mw: directed vector table, corner sequences, and a
// random phase compared every cycle against a queue-of-bits reference model.
module tb_gtxe2_chnl_tx_ser_mw;
  localparam int MW = 40;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [1:0]    width_sel = 2'd0;
  logic [MW-1:0] in_data = '0;
  logic          in_idle = 1'b0;
  logic          in_val = 1'b0;
  logic          in_rdy, outdata, idle_out, word_start, underflow;

  gtxe2_chnl_tx_ser_mw #(.max_width(MW), .log_depth(2)) dut (
    .outclk(clk), .reset(reset), .width_sel(width_sel), .in_data(in_data),
    .in_idle(in_idle), .in_val(in_val), .in_rdy(in_rdy), .outdata(outdata),
    .idle_out(idle_out), .word_start(word_start), .underflow(underflow)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check1(string name, logic act, logic exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkn(string name, int act, int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model: FIFO of words, queue of pending output bits
  typedef struct packed { logic b; logic idl; logic st; } rec_t;
  typedef struct packed { logic idl; logic [MW-1:0] d; } word_t;

  word_t fifo_m[$];
  rec_t  cur_m[$];
  logic  uf_pend_m = 1'b0;
  logic  e_out = 1'b0, e_idle = 1'b1, e_ws = 1'b0, e_uf = 1'b0, e_rdy = 1'b1;

  function automatic int wbits(logic [1:0] s);
    case (s)
      2'd0:    return 16;
      2'd1:    return 20;
      2'd2:    return 32;
      default: return 40;
    endcase
  endfunction

  function automatic logic pick(logic [MW-1:0] d, int w, int i);
`ifdef GTXE2_TX_SER_MSB_FIRST_EN
    return d[w-1-i];
`else
    return d[i];
`endif
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      fifo_m.delete();
      cur_m.delete();
      uf_pend_m = 1'b0;
      {e_out, e_idle, e_ws, e_uf, e_rdy} = 5'b01001;
    end else begin
      bit   rdy_pre;
      bit   had;
      rec_t r;
      rdy_pre   = fifo_m.size() < 4;
      e_uf      = uf_pend_m;
      uf_pend_m = 1'b0;
      had       = cur_m.size() > 0;
      if (had) begin
        r = cur_m.pop_front();
        {e_out, e_idle, e_ws} = {r.b, r.idl, r.st};
      end else begin
        {e_out, e_idle, e_ws} = 3'b010;
      end
      if (cur_m.size() == 0) begin
        if (fifo_m.size() > 0) begin
          word_t wd;
          int    w;
          wd = fifo_m.pop_front();
          w  = wbits(width_sel);
          for (int i = 0; i < w; i++)
            cur_m.push_back('{b: wd.idl ? 1'b0 : pick(wd.d, w, i), idl: wd.idl, st: (i == 0)});
        end else if (had) begin
          uf_pend_m = 1'b1;
        end
      end
      if (in_val && rdy_pre) fifo_m.push_back('{idl: in_idle, d: in_data});
      e_rdy = fifo_m.size() < 4;
    end
  end

  always @(negedge clk) begin
    check1("m_outdata", outdata, e_out);
    check1("m_idle_out", idle_out, e_idle);
    check1("m_word_start", word_start, e_ws);
    check1("m_underflow", underflow, e_uf);
    check1("m_in_rdy", in_rdy, e_rdy);
  end

  // ---------------- directed vector table
  typedef struct {
    logic [1:0]    wsel;
    logic          idle;
    logic [MW-1:0] data;
    logic [MW-1:0] seq;   // seq[i] = i-th emitted bit
  } vec_t;

  vec_t vecs[6];

  task automatic run_vec(int k, vec_t v);
    int w;
    w = wbits(v.wsel);
    repeat (60) @(negedge clk);
    width_sel = v.wsel; in_idle = v.idle; in_data = v.data; in_val = 1'b1;
    @(negedge clk);
    in_val = 1'b0; in_idle = 1'b0;
    check1($sformatf("vec%0d ws@t", k), word_start, 1'b0);
    @(negedge clk);
    check1($sformatf("vec%0d ws@t+1", k), word_start, 1'b0);
    @(negedge clk);
    for (int i = 0; i < w; i++) begin
      check1($sformatf("vec%0d bit%0d", k, i), outdata, v.seq[i]);
      check1($sformatf("vec%0d idle%0d", k, i), idle_out, v.idle);
      check1($sformatf("vec%0d ws%0d", k, i), word_start, (i == 0));
      @(negedge clk);
    end
    check1($sformatf("vec%0d underflow", k), underflow, 1'b1);
    check1($sformatf("vec%0d fill idle", k), idle_out, 1'b1);
    check1($sformatf("vec%0d fill data", k), outdata, 1'b0);
    @(negedge clk);
    check1($sformatf("vec%0d underflow pulse", k), underflow, 1'b0);
  endtask

  initial begin
    int ws_cnt, first, last_ws, sent, cyc_ws2, cyc_uf;
    bit rdy_low, uf_seen, uf_end, found;

    vecs[0] = '{2'd1, 1'b0, 40'h00000A5F0F, 40'h00000A5F0F};
    vecs[1] = '{2'd0, 1'b1, 40'h000000FFFF, 40'h0000000000};
    vecs[2] = '{2'd0, 1'b0, 40'h0000008001, 40'h0000008001};
    vecs[3] = '{2'd2, 1'b0, 40'h0012345678, 40'h0012345678};
    vecs[4] = '{2'd0, 1'b0, 40'hFFFFFF0003, 40'h0000000003};
    vecs[5] = '{2'd3, 1'b0, 40'h8000000001, 40'h8000000001};
`ifdef GTXE2_TX_SER_MSB_FIRST_EN
    vecs[0].seq = 40'h00000F0FA5;
    vecs[3].seq = 40'h001E6A2C48;
    vecs[4].seq = 40'h000000C000;
`endif

    repeat (3) @(negedge clk);
    check1("reset outdata", outdata, 1'b0);
    check1("reset idle_out", idle_out, 1'b1);
    check1("reset word_start", word_start, 1'b0);
    check1("reset underflow", underflow, 1'b0);
    check1("reset in_rdy", in_rdy, 1'b1);
    reset = 1'b0;

    for (int k = 0; k < 6; k++) run_vec(k, vecs[k]);

    // Streaming: 8 words at width 16, in_val held high.
    repeat (60) @(negedge clk);
    width_sel = 2'd0; sent = 0; ws_cnt = 0; first = -1; last_ws = -1;
    rdy_low = 0; uf_seen = 0; uf_end = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (word_start) begin
        ws_cnt++;
        if (first < 0) first = cyc;
        last_ws = cyc;
      end
      if (!in_rdy) rdy_low = 1;
      if (first >= 0 && cyc < first + 128 && underflow) uf_seen = 1;
      if (first >= 0 && cyc == first + 128) uf_end = underflow;
      in_val = (sent < 8);
      in_data = MW'({$urandom, $urandom});
      if (in_val && in_rdy) sent++;
      @(negedge clk);
    end
    in_val = 1'b0;
    checkn("stream sent", sent, 8);
    checkn("stream word starts", ws_cnt, 8);
    checkn("stream last start offset", last_ws - first, 112);
    check1("stream in_rdy dropped", rdy_low, 1'b1);
    check1("stream early underflow", uf_seen, 1'b0);
    check1("stream end underflow", uf_end, 1'b1);

    // Width change mid-word: 32-bit word, then a 40-bit word.
    repeat (60) @(negedge clk);
    width_sel = 2'd2; in_data = MW'({$urandom, $urandom}); in_val = 1'b1;
    @(negedge clk);
    in_data = MW'({$urandom, $urandom});
    @(negedge clk);
    in_val = 1'b0;
    first = -1; cyc_ws2 = -1; cyc_uf = -1; ws_cnt = 0;
    for (int cyc = 0; cyc < 120; cyc++) begin
      @(negedge clk);
      if (word_start) begin
        ws_cnt++;
        if (first < 0) first = cyc; else cyc_ws2 = cyc;
      end
      if (underflow && cyc_uf < 0) cyc_uf = cyc;
      if (cyc == 5)  width_sel = 2'd0;
      if (cyc == 12) width_sel = 2'd1;
      if (cyc == 18) width_sel = 2'd3;
    end
    checkn("toggle first start", first, 0);
    checkn("toggle word starts", ws_cnt, 2);
    checkn("toggle word1 length", cyc_ws2 - first, 32);
    checkn("toggle word2 length", cyc_uf - cyc_ws2, 40);

    // Reset at bit 7 with three words queued; coincident push must be dropped.
    repeat (60) @(negedge clk);
    width_sel = 2'd0; in_val = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_data = MW'({$urandom, $urandom});
      @(negedge clk);
    end
    in_val = 1'b0;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (word_start) found = 1; else @(negedge clk);
    end
    check1("rst word start seen", found, 1'b1);
    repeat (7) @(negedge clk);
    reset = 1'b1; in_val = 1'b1; in_data = MW'({$urandom, $urandom});
    @(negedge clk);
    reset = 1'b0; in_val = 1'b0;
    check1("midrst outdata", outdata, 1'b0);
    check1("midrst idle_out", idle_out, 1'b1);
    check1("midrst word_start", word_start, 1'b0);
    check1("midrst underflow", underflow, 1'b0);
    check1("midrst in_rdy", in_rdy, 1'b1);
    ws_cnt = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (word_start || !idle_out) ws_cnt++;
    end
    checkn("midrst queued words emitted", ws_cnt, 0);

    // Random phase, checked every cycle by the model.
    for (int i = 0; i < 3000; i++) begin
      in_val  = ($urandom_range(0, 99) < 55);
      in_data = MW'({$urandom, $urandom});
      in_idle = ($urandom_range(0, 99) < 10);
      if ($urandom_range(0, 49) == 0) width_sel = 2'($urandom);
      reset   = ($urandom_range(0, 999) == 0);
      @(negedge clk);
    end
    reset = 1'b0; in_val = 1'b0; in_idle = 1'b0;
    repeat (200) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
